l2_sweep_array: RTL and testbench

L2_SWEEP_ARRAY -- requirements
Module: l2_sweep_array

---
 rtl/l2_sweep_array.sv | 108 ++++++++++
 tb/tb_l2_sweep_array.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_sweep_array.sv
// l2_sweep_array
//   Single-port-addressed storage array that zeroes itself after reset or a
//   clear request. While the zeroing sweep is in progress, ready is low and
//   read and write requests are ignored. Once the sweep finishes, the array
//   serves one read and/or one write per cycle, addressed by a shared index.
//
// Ports
//   clk      : single clock; all state updates on its rising edge
//   reset_n  : synchronous active-low reset
//   clear    : one-cycle request to restart the zeroing sweep
//   read     : read request (accepted only while ready=1)
//   write    : write request (accepted only while ready=1)
//   index    : entry address for read and write
//   datain   : write data
//   dataout  : registered read data; holds its value when resp=0
//   resp     : dataout-valid pulse, one cycle after an accepted read
//   ready    : array initialised and accepting requests
//
// Configuration macro
//   L2_SWEEP_ARRAY_BYPASS_EN : when defined, a read and write issued in the
//   same cycle return datain (write-first). When undefined, they return the
//   previously stored value (read-first).
module l2_sweep_array #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             read,
  input  logic             write,
  input  logic [IDX_W-1:0] index,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  output logic             resp,
  output logic             ready
);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] sweep_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             sweep_last;
  logic             rd_en;
  logic             wr_en;

  assign sweep_last = (sweep_ptr == IDX_W'(DEPTH - 1));
  // A clear in RUN drops any read or write presented in the same cycle.
  assign rd_en      = ready && read  && !clear && reset_n;
  assign wr_en      = ready && write && !clear && reset_n;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= SWEEP;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      SWEEP: if (!clear && sweep_last) state_next = RUN;
      RUN:   if (clear)                state_next = SWEEP;
      default: state_next = SWEEP;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state == RUN);
  end

  // Sweep pointer: parked at 0 in RUN so a clear starts from entry 0;
  // DEPTH is a power of two, so the final increment wraps to 0 as well.
  always_ff @(posedge clk) begin
    if (!reset_n)                   sweep_ptr <= '0;
    else if (state == RUN || clear) sweep_ptr <= '0;
    else                            sweep_ptr <= sweep_ptr + IDX_W'(1);
  end

  // Storage: the sweep owns the write port until it completes.
  always_ff @(posedge clk) begin
    if (state == SWEEP) mem[sweep_ptr] <= '0;
    else if (wr_en)     mem[index]     <= datain;
  end

  // Read response. Read and write share one index, so a same-cycle read and
  // write always collide on the same entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp    <= 1'b0;
      dataout <= '0;
    end else begin
      resp <= rd_en;
      if (rd_en) begin
`ifdef L2_SWEEP_ARRAY_BYPASS_EN
        dataout <= wr_en ? datain : mem[index];
`else
        dataout <= mem[index];
`endif
      end
    end
  end

endmodule

// File: tb/tb_l2_sweep_array.sv
module tb_l2_sweep_array;

  localparam int WIDTH   = 128;
  localparam int DEPTH   = 32;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int B_WIDTH = 32;
  localparam int B_DEPTH = 8;
  localparam int B_IDX_W = $clog2(B_DEPTH);

  logic clk;

  // Default-parameter instance
  logic             reset_n, clear, read, write;
  logic [IDX_W-1:0] index;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             resp, ready;

  // Small instance (WIDTH=32, DEPTH=8)
  logic               b_reset_n, b_clear, b_read, b_write;
  logic [B_IDX_W-1:0] b_index;
  logic [B_WIDTH-1:0] b_datain;
  logic [B_WIDTH-1:0] b_dataout;
  logic               b_resp, b_ready;

  int n_cmp;
  int n_err;

  l2_sweep_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .read(read), .write(write),
    .index(index), .datain(datain), .dataout(dataout), .resp(resp), .ready(ready)
  );

  l2_sweep_array #(.WIDTH(B_WIDTH), .DEPTH(B_DEPTH)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .clear(b_clear), .read(b_read), .write(b_write),
    .index(b_index), .datain(b_datain), .dataout(b_dataout), .resp(b_resp), .ready(b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read = 1'b0; write = 1'b0; clear = 1'b0;
  endtask

  task automatic b_idle();
    b_read = 1'b0; b_write = 1'b0; b_clear = 1'b0;
  endtask

  // Counts edges until ready rises; bounded so a stuck DUT still ends.
  task automatic wait_ready(output int n);
    n = 0;
    do begin tick(); n++; end while (!ready && n < 200);
  endtask

  task automatic b_wait_ready(output int n);
    n = 0;
    do begin tick(); n++; end while (!b_ready && n < 200);
  endtask

  localparam logic [127:0] V5   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000005;
  localparam logic [127:0] VA   = 128'h11111111_22222222_33333333_4444444A;
  localparam logic [127:0] VB   = 128'h55555555_66666666_77777777_8888888B;
  localparam logic [127:0] VX   = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
  localparam logic [127:0] COLL_EXP =
`ifdef L2_SWEEP_ARRAY_BYPASS_EN
    VB;
`else
    VA;
`endif
  localparam logic [31:0] B_COLL_EXP =
`ifdef L2_SWEEP_ARRAY_BYPASS_EN
    32'hBBBB0007;
`else
    32'hAAAA0007;
`endif

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    idle(); b_idle();
    index = '0; datain = '0; b_index = '0; b_datain = '0;
    reset_n = 1'b0; b_reset_n = 1'b0;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_resp", 128'(resp), 128'(0));
    chk("rst_dataout", dataout, 128'(0));
    reset_n = 1'b1;
    wait_ready(n);
    chk("rst_sweep_cycles", 128'(n), 128'(DEPTH));

    read = 1'b1; index = 3;
    tick();
    chk("rd3_resp", 128'(resp), 128'(1));
    chk("rd3_data", dataout, 128'(0));
    idle();
    tick();
    chk("idle_resp", 128'(resp), 128'(0));

    // ---------------- write / read ----------------
    write = 1'b1; index = 5; datain = V5;
    tick();
    chk("wr5_resp", 128'(resp), 128'(0));
    idle(); read = 1'b1; index = 5;
    tick();
    chk("rd5_resp", 128'(resp), 128'(1));
    chk("rd5_data", dataout, V5);
    index = 6;
    tick();
    chk("rd6_resp", 128'(resp), 128'(1));
    chk("rd6_data", dataout, 128'(0));
    index = 5;
    tick();
    chk("rd5b_data", dataout, V5);
    idle();
    tick();
    chk("hold_resp", 128'(resp), 128'(0));
    chk("hold_data", dataout, V5);

    // ---------------- same-index collision ----------------
    write = 1'b1; index = 9; datain = VA;
    tick();
    read = 1'b1; write = 1'b1; index = 9; datain = VB;
    tick();
    chk("coll_resp", 128'(resp), 128'(1));
    chk("coll_data", dataout, COLL_EXP);
    write = 1'b0;
    tick();
    chk("coll_after", dataout, VB);
    idle();

    // ---------------- clear ----------------
    for (int i = 0; i < DEPTH; i++) begin
      write = 1'b1; index = IDX_W'(i); datain = {4{32'(i + 1)}};
      tick();
    end
    idle(); read = 1'b1; index = 17;
    tick();
    chk("fill17", dataout, {4{32'd18}});
    // clear with a read and write in the same cycle: both dropped
    clear = 1'b1; read = 1'b1; write = 1'b1; index = 1; datain = VX;
    tick();
    chk("clr_ready", 128'(ready), 128'(0));
    chk("clr_resp", 128'(resp), 128'(0));
    idle();
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("clr_busy", 128'(ready), 128'(0));
    // a write to entry 0 on the final sweep cycle must not land
    write = 1'b1; read = 1'b1; index = 0; datain = VX;
    tick();
    chk("clr_done_ready", 128'(ready), 128'(1));
    chk("clr_sweep_rd_resp", 128'(resp), 128'(0));
    idle();
    read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      index = IDX_W'(i);
      tick();
      chk($sformatf("clr_rd%0d", i), dataout, 128'(0));
    end
    chk("clr_rd_resp", 128'(resp), 128'(1));
    idle();

    // ---------------- clear during sweep restarts ----------------
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_ready(n);
    chk("reclear_cycles", 128'(n), 128'(DEPTH));

    // ---------------- reset mid-read ----------------
    write = 1'b1; index = 3; datain = VA;
    tick();
    write = 1'b0; read = 1'b1; index = 3; reset_n = 1'b0;
    tick();
    chk("rstrd_resp", 128'(resp), 128'(0));
    chk("rstrd_data", dataout, 128'(0));
    idle(); reset_n = 1'b1;
    wait_ready(n);
    chk("rstrd_cycles", 128'(n), 128'(DEPTH));
    read = 1'b1; index = 3;
    tick();
    chk("rstrd_rd3", dataout, 128'(0));
    idle();

    // ---------------- reset mid-sweep ----------------
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("rstsw_ready", 128'(ready), 128'(0));
    reset_n = 1'b1;
    wait_ready(n);
    chk("rstsw_cycles", 128'(n), 128'(DEPTH));

    // ---------------- WIDTH=32, DEPTH=8 instance ----------------
    b_reset_n = 1'b1;
    b_wait_ready(n);
    chk("b_sweep_cycles", 128'(n), 128'(B_DEPTH));
    b_write = 1'b1; b_index = 5; b_datain = 32'hDEAD0005;
    tick();
    b_idle(); b_read = 1'b1; b_index = 5;
    tick();
    chk("b_rd5_resp", 128'(b_resp), 128'(1));
    chk("b_rd5_data", 128'(b_dataout), 128'(32'hDEAD0005));
    b_index = 6;
    tick();
    chk("b_rd6_data", 128'(b_dataout), 128'(0));
    b_idle(); b_write = 1'b1; b_index = 7; b_datain = 32'hAAAA0007;
    tick();
    b_read = 1'b1; b_datain = 32'hBBBB0007;
    tick();
    chk("b_coll_data", 128'(b_dataout), 128'(B_COLL_EXP));
    b_write = 1'b0;
    tick();
    chk("b_coll_after", 128'(b_dataout), 128'(32'hBBBB0007));
    b_idle(); b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    b_wait_ready(n);
    chk("b_clr_cycles", 128'(n), 128'(B_DEPTH));
    b_read = 1'b1; b_index = 7;
    tick();
    chk("b_clr_rd7", 128'(b_dataout), 128'(0));
    b_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
